// File: rtl/ibex_fetch_aligner_pkg.sv
// Shared types and helpers for the fetch aligner and its output register.
package ibex_fetch_aligner_pkg;

  typedef enum logic {
    ALIGN_EMPTY = 1'b0,
    ALIGN_HALF  = 1'b1
  } align_state_e;

  localparam int unsigned PAYLOAD_W = 67;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        compressed;
    logic        err;
    logic        err_plus2;
  } instr_pkt_t;

  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_fetch_aligner_out_reg.sv
// One-entry valid/ready output register with flush; load is exported so the
// aligner can decide whether it may consume or emit this cycle.
module ibex_fetch_out_reg
  import ibex_fetch_aligner_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 load,
  output logic                 valid,
  input  logic                 ready,
  output logic [PAYLOAD_W-1:0] data
);

  logic                 valid_q;
  logic [PAYLOAD_W-1:0] data_q;

  assign load  = !valid_q | ready;
  assign valid = valid_q;
  assign data  = data_q;

  // A flush wins over a load; a handshake in the same cycle still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

// File: rtl/ibex_fetch_aligner.sv
// Splits prefetch words into whole RV32IC instructions, holding a spare
// halfword between words when an instruction straddles a word boundary.
//
// state       | meaning
// ALIGN_EMPTY | no halfword held; next word starts a new instruction
// ALIGN_HALF  | hold_q carries a halfword not yet emitted
module ibex_fetch_aligner
  import ibex_fetch_aligner_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_valid_i,
  input  logic [31:0] fetch_rdata_i,
  input  logic [31:0] fetch_addr_i,
  input  logic        fetch_err_i,
  output logic        fetch_ready_o,
  input  logic        branch_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_o,
  output logic        instr_is_compressed_o,
  output logic        instr_err_o,
  output logic        instr_err_plus2_o,
  output logic        busy_o
);

  align_state_e state_q, state_d;
  logic [15:0]  hold_q, hold_d;
  logic [31:0]  hold_addr_q, hold_addr_d;
  logic         hold_err_q, hold_err_d;
  logic         drop_q, drop_d;

  logic         load;
  logic         emit;
  instr_pkt_t   pkt;
  instr_pkt_t   out_pkt;
  logic [PAYLOAD_W-1:0] out_data;

  logic [15:0] lo_hw, hi_hw;
  assign lo_hw = fetch_rdata_i[15:0];
  assign hi_hw = fetch_rdata_i[31:16];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ALIGN_EMPTY;
      hold_q      <= '0;
      hold_addr_q <= '0;
      hold_err_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_addr_q <= hold_addr_d;
      hold_err_q  <= hold_err_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    hold_addr_d   = hold_addr_q;
    hold_err_d    = hold_err_q;
    drop_d        = drop_q;
    fetch_ready_o = 1'b0;
    emit          = 1'b0;
    pkt           = '0;

    if (branch_i) begin
      state_d = ALIGN_EMPTY;
      drop_d  = 1'b0;
    end else if (drop_q) begin
      fetch_ready_o = 1'b1;
      state_d       = ALIGN_EMPTY;
    end else begin
      unique case (state_q)
        ALIGN_EMPTY: begin
          fetch_ready_o = load;
          if (fetch_valid_i && load) begin
            if (!fetch_addr_i[1]) begin
              emit    = 1'b1;
              pkt.addr = fetch_addr_i;
              pkt.err  = fetch_err_i;
              if (is_compressed(lo_hw)) begin
                pkt.rdata   = {16'h0000, lo_hw};
                hold_d      = hi_hw;
                hold_addr_d = fetch_addr_i + 32'd2;
                hold_err_d  = fetch_err_i;
                state_d     = ALIGN_HALF;
              end else begin
                pkt.rdata = fetch_rdata_i;
              end
            end else if (is_compressed(hi_hw)) begin
              emit      = 1'b1;
              pkt.rdata = {16'h0000, hi_hw};
              pkt.addr  = fetch_addr_i;
              pkt.err   = fetch_err_i;
            end else begin
              hold_d      = hi_hw;
              hold_addr_d = fetch_addr_i;
              hold_err_d  = fetch_err_i;
              state_d     = ALIGN_HALF;
            end
          end
        end
        ALIGN_HALF: begin
          if (is_compressed(hold_q)) begin
            // Second half of a compressed pair goes out without touching input.
            emit      = 1'b1;
            pkt.rdata = {16'h0000, hold_q};
            pkt.addr  = hold_addr_q;
            pkt.err   = hold_err_q;
            if (load) state_d = ALIGN_EMPTY;
          end else begin
            fetch_ready_o = load;
            if (fetch_valid_i && load) begin
              emit          = 1'b1;
              pkt.rdata     = {lo_hw, hold_q};
              pkt.addr      = hold_addr_q;
              pkt.err       = hold_err_q | fetch_err_i;
              pkt.err_plus2 = !hold_err_q & fetch_err_i;
              hold_d        = hi_hw;
              hold_addr_d   = hold_addr_q + 32'd4;
              hold_err_d    = fetch_err_i;
            end
          end
        end
        default: state_d = ALIGN_EMPTY;
      endcase

      // Once a faulting instruction is handed on, everything up to the next
      // branch is discarded.
      if (emit && load && pkt.err) begin
        drop_d  = 1'b1;
        state_d = ALIGN_EMPTY;
      end
    end

    pkt.compressed = is_compressed(pkt.rdata[15:0]);
  end

  ibex_fetch_out_reg u_out_reg (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .flush    (branch_i),
    .in_valid (emit),
    .in_data  (pkt),
    .load     (load),
    .valid    (instr_valid_o),
    .ready    (instr_ready_i),
    .data     (out_data)
  );

  assign out_pkt               = out_data;
  assign instr_rdata_o         = out_pkt.rdata;
  assign instr_addr_o          = out_pkt.addr;
  assign instr_is_compressed_o = out_pkt.compressed;
  assign instr_err_o           = out_pkt.err;
  assign instr_err_plus2_o     = out_pkt.err_plus2;
  assign busy_o                = (state_q == ALIGN_HALF) | instr_valid_o;

endmodule

// File: doc/ibex_fetch_aligner.md
# ibex_fetch_aligner

Instruction aligner between the single prefetch buffer and the ID stage. It takes the buffer's stream of 32-bit fetch words, which may arrive at halfword-aligned addresses after a branch. It extracts whole RV32IC instructions: 16-bit compressed ones and 32-bit ones straddling word boundaries. Each instruction is presented through a one-entry registered valid/ready output stage.

## Interface
Parameters:
- none

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- fetch_valid_i  in  1  word from prefetch buffer valid
- fetch_rdata_i  in  32  fetch word, as returned from the word-aligned address
- fetch_addr_i  in  32  address of the word; bit 1 set only on the first word after a branch
- fetch_err_i  in  1  bus error on this word
- fetch_ready_o  out  1  aligner consumes the word this cycle; drives the buffer's ready_i
- branch_i  in  1  flush; same pulse as the buffer's branch_i
- instr_valid_o  out  1  output instruction valid
- instr_ready_i  in  1  ID stage accepts
- instr_rdata_o  out  32  instruction; upper 16 bits zero when compressed
- instr_addr_o  out  32  instruction PC
- instr_is_compressed_o  out  1  rdata[1:0] != 2'b11
- instr_err_o  out  1  fetch error attached to this instruction
- instr_err_plus2_o  out  1  error came from the second halfword of a straddling instruction
- busy_o  out  1  holding halfword or output register occupied

## Operation
- State: align_state_e is EMPTY or HALF.
  - HALF holds hold_q[15:0], hold_addr_q and hold_err_q.
- Output register (valid_q plus payload) loads when `load = !valid_q | instr_ready_i`.
- EMPTY, fetch word accepted (fetch_ready_o = load):
  - fetch_addr_i[1] = 0, lower half compressed: emit lower half at addr. Store upper half in hold, addr + 2, then go to HALF.
  - fetch_addr_i[1] = 0, lower half not compressed: emit the full word. Stay in EMPTY.
  - fetch_addr_i[1] = 1, upper half compressed: emit it. Stay in EMPTY.
  - fetch_addr_i[1] = 1, upper half not compressed: store it in hold, then go to HALF. Nothing is emitted.
- HALF, held halfword compressed:
  - Emit it without consuming input: fetch_ready_o = 0. Go to EMPTY when load.
- HALF, held halfword not compressed:
  - Consume the word (fetch_ready_o = load).
  - Emit {rdata[15:0], hold_q} at hold_addr_q.
  - Store rdata[31:16] at hold_addr_q + 4. Stay in HALF.
- Errors:
  - Error on a directly emitted word: err_o = 1, err_plus2_o = 0.
  - Straddling instruction with a second-word error: err_o = 1, err_plus2_o = 1.
  - First-half error (hold_err_q) takes priority: err_plus2_o = 0.
  - After loading any error instruction, set drop_q. While drop_q is set: fetch_ready_o = 1, input words are discarded, state = EMPTY. drop_q clears on branch_i.
- branch_i, highest priority:
  - Clear state to EMPTY, clear valid_q and drop_q. The input word that cycle is ignored (fetch_ready_o = 0).
- Address arithmetic is 32-bit with modulo wrap: 0xFFFF_FFFE + 2 = 0x0000_0000.

## Timing
- Reset values: all outputs 0 except fetch_ready_o, which is 1 (EMPTY, output register empty). State = EMPTY.
- Latency: fetch word accepted in cycle N gives instr_valid_o in cycle N+1. A straddling instruction appears one cycle after its second word.
- fetch_ready_o depends only on state, valid_q, instr_ready_i and branch_i. It never depends on fetch_valid_i.
- instr_valid_o stays high, with payload stable, until instr_ready_i is high. Exception: branch_i may drop it.
- Back-to-back throughput: one instruction per cycle while instr_ready_i = 1.
- Compressed pair: two cycles per word. The second cycle does not consume input.
- A branch in the same cycle as an output handshake: the handshake completes, and the register is then empty.
- Reset asserted mid-HALF: hold is discarded asynchronously.

## Structure
- align_state_e and a function is_compressed(logic [15:0]) belong in the shared ibex package.
- The output stage is a natural sub-module, ibex_fetch_out_reg: a one-entry valid/ready register with flush and a payload of 32 + 32 + 3 bits.

## Test plan
- Words 0x00500093 @0x100 and 0x00A00113 @0x104, ready held high → outputs @0x100 and @0x104, is_compressed = 0, each one cycle after its word.
- Word 0x45054501 @0x200 → 0x00004501 @0x200, then 0x00004505 @0x202. fetch_ready_o = 0 during the second cycle.
- Words 0x00934501 @0x300 and 0x00000050 @0x304 → 0x4501 @0x300, then 0x00500093 @0x302 with is_compressed = 0. Hold then contains 0x0000 @0x306.
- Branch to 0x402, then word 0x4505ABCD @0x402 → single output 0x00004505 @0x402. The lower half is never emitted.
- Same as scenario 3 but with fetch_err_i = 1 on 0x304 → output @0x302 with err_o = 1, err_plus2_o = 1. Further words are accepted and dropped until branch_i.
- ID stalls (instr_ready_i = 0) for 5 cycles with HALF pending → output payload stable and fetch_ready_o = 0. A branch_i pulse then gives instr_valid_o = 0 next cycle, and a mid-stall reset returns all outputs to their reset values.
